// File: rtl/inst_mem_loader.sv
// -----------------------------------------------------------------------------
// inst_mem_loader
//
// Writable instruction memory for the ARM pipeline. A byte-serial loader
// stream fills an internal word RAM. The IF stage reads through a
// combinational fetch port that behaves like the old hard-coded ROM. The core
// is held (loading=1) while a program is being written.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit instruction words stored
//   IDX_W       : word-index width, must equal clog2(DEPTH_WORDS)
//
// Ports
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   ld_start    : one-cycle pulse, (re)starts a load session from any state
//   ld_valid    : loader byte valid
//   ld_byte     : loader byte, MSB byte of each word first
//   ld_last     : final byte of the program (qualified by ld_valid)
//   ld_ready    : a byte can be accepted this cycle (state LOAD)
//   address     : fetch byte address (PC) from IF
//   Inst        : fetched instruction, 0 (NOP) when not a valid hit
//   loading     : high in LOAD, core must be frozen
//   load_done   : high in DONE, program valid
//   word_count  : words written in the current session
//   err         : sticky session error (partial last word or overflow)
// -----------------------------------------------------------------------------
module inst_mem_loader #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_start,
    input  logic             ld_valid,
    input  logic [7:0]       ld_byte,
    input  logic             ld_last,
    output logic             ld_ready,
    input  logic [31:0]      address,
    output logic [31:0]      Inst,
    output logic             loading,
    output logic             load_done,
    output logic [IDX_W:0]   word_count,
    output logic             err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Index of the final RAM slot; writing it ends the session.
    localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'(DEPTH_WORDS - 1);

    logic [1:0]  state;
    logic [1:0]  byte_cnt;   // bytes already collected for the current word
    logic [31:0] shreg;      // earlier bytes of the current word, right-aligned

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        word_end;
    logic        last_slot;
    logic [31:0] wr_data;

    // -------------------------------------------------------------------------
    // Loader handshake
    // -------------------------------------------------------------------------
    assign ld_ready  = (state == S_LOAD);
    assign loading   = (state == S_LOAD);
    assign load_done = (state == S_DONE);

    // ld_start takes priority: a byte presented on the start cycle is dropped.
    assign accept    = ld_valid && ld_ready && !ld_start;

    // A word is committed on its 4th byte, or early when ld_last cuts it short.
    assign word_end  = accept && ((byte_cnt == 2'd3) || ld_last);
    assign last_slot = (word_count == LAST_IDX);

    // Assemble the word to write. Earlier bytes sit right-aligned in shreg;
    // the incoming byte follows them and any missing low bytes are zero.
    always_comb begin
        wr_data = 32'b0;
        case (byte_cnt)
            2'd0:    wr_data = {ld_byte, 24'b0};
            2'd1:    wr_data = {shreg[7:0], ld_byte, 16'b0};
            2'd2:    wr_data = {shreg[15:0], ld_byte, 8'b0};
            default: wr_data = {shreg[23:0], ld_byte};
        endcase
    end

    // -------------------------------------------------------------------------
    // Session FSM, byte counter, word counter and error flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            byte_cnt   <= 2'd0;
            shreg      <= 32'b0;
            word_count <= '0;
            err        <= 1'b0;
        end else if (ld_start) begin
            // Valid from IDLE, DONE and mid-LOAD (restart).
            state      <= S_LOAD;
            byte_cnt   <= 2'd0;
            shreg      <= 32'b0;
            word_count <= '0;
            err        <= 1'b0;
        end else if (accept) begin
            if (word_end) begin
                word_count <= word_count + (IDX_W+1)'(1);
                byte_cnt   <= 2'd0;
                shreg      <= 32'b0;
                if (ld_last) begin
                    state <= S_DONE;
                    // Program ended mid-word: the padded word is suspect.
                    if (byte_cnt != 2'd3)
                        err <= 1'b1;
                end else if (last_slot) begin
                    // RAM is full but the stream said there is more.
                    state <= S_DONE;
                    err   <= 1'b1;
                end
            end else begin
                byte_cnt <= byte_cnt + 2'd1;
                shreg    <= {shreg[23:0], ld_byte};
            end
        end
    end

    // -------------------------------------------------------------------------
    // Instruction RAM. Contents are deliberately not reset; stale words are
    // hidden by the word_count gate on the read side.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (word_end)
            mem[word_count[IDX_W-1:0]] <= wr_data;
    end

    // -------------------------------------------------------------------------
    // Fetch port. Word-aligned: address[1:0] is ignored. Anything outside the
    // loaded program, or any fetch while not DONE, returns the NOP encoding 0.
    // Reads only happen in DONE, so a same-index write/read never overlaps.
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] idx;
    logic             hit;

    assign idx = address[IDX_W+1:2];
    assign hit = (state == S_DONE)
              && (address[31:IDX_W+2] == '0)
              && ({1'b0, idx} < word_count);

    assign Inst = hit ? mem[idx] : 32'b0;

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic [31:0] address = 32'd0;

    // Default-depth instance
    logic        ld_ready, loading, load_done, err;
    logic [31:0] Inst;
    logic [10:0] word_count;

    // Four-word instance for the overflow case; shares all inputs
    logic        ld_ready4, loading4, load_done4, err4;
    logic [31:0] Inst4;
    logic [2:0]  word_count4;

    always #5 clk = ~clk;

    inst_mem_loader #(.DEPTH_WORDS(1024), .IDX_W(10)) dut (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready),
        .address(address), .Inst(Inst), .loading(loading),
        .load_done(load_done), .word_count(word_count), .err(err)
    );

    inst_mem_loader #(.DEPTH_WORDS(4), .IDX_W(2)) dut4 (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready4),
        .address(address), .Inst(Inst4), .loading(loading4),
        .load_done(load_done4), .word_count(word_count4), .err(err4)
    );

    // Check kinds
    localparam int K_INST = 0, K_WC = 1, K_ERR = 2, K_DONE = 3, K_LOADING = 4,
                   K_READY = 5, K_INST4 = 6, K_WC4 = 7, K_ERR4 = 8,
                   K_DONE4 = 9, K_READY4 = 10;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic void expect_val(input int kind, input logic [31:0] a,
                                       input logic [31:0] e, input string nm);
        chk_t c;
        c.kind = kind; c.addr = a; c.exp = e; c.name = nm;
        sb.push_back(c);
    endfunction

    // Monitor: one check per cycle, sampled mid-cycle away from the edge
    chk_t        mc;
    logic [31:0] act;
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mc = sb.pop_front();
            address = mc.addr;
            #1;
            case (mc.kind)
                K_INST:    act = Inst;
                K_WC:      act = {21'b0, word_count};
                K_ERR:     act = {31'b0, err};
                K_DONE:    act = {31'b0, load_done};
                K_LOADING: act = {31'b0, loading};
                K_READY:   act = {31'b0, ld_ready};
                K_INST4:   act = Inst4;
                K_WC4:     act = {29'b0, word_count4};
                K_ERR4:    act = {31'b0, err4};
                K_DONE4:   act = {31'b0, load_done4};
                K_READY4:  act = {31'b0, ld_ready4};
                default:   act = 32'hDEAD_BEEF;
            endcase
            tests++;
            if (act !== mc.exp) begin
                fails++;
                $display("FAIL %s: got %h, expected %h", mc.name, act, mc.exp);
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (sb.size() != 0) begin
            @(posedge clk);
            n++;
            if (n > 500) begin
                $display("FAIL drain: %0d checks still queued, expected 0", sb.size());
                $fatal(1);
            end
        end
        #1;
    endtask

    task automatic pulse_start(input logic with_byte, input logic [7:0] b);
        ld_start = 1'b1;
        ld_valid = with_byte;
        ld_byte  = b;
        @(posedge clk); #1;
        ld_start = 1'b0;
        ld_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic last, input int gap,
                        input logic chk_loading);
        repeat (gap) @(posedge clk);
        #1;
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        if (chk_loading) expect_val(K_LOADING, 0, 1, "loading_during_load");
        @(posedge clk); #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 4; i++)
            send(t[31-8*i -: 8], last && (i == 3), 0, 1'b0);
    endtask

    initial begin
        logic [7:0] bytes3 [12];
        logic [31:0] w3 [3];
        rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_byte = 8'h00; ld_last = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        expect_val(K_READY,   0, 0, "rst_ld_ready");
        expect_val(K_LOADING, 0, 0, "rst_loading");
        expect_val(K_DONE,    0, 0, "rst_load_done");
        expect_val(K_WC,      0, 0, "rst_word_count");
        expect_val(K_ERR,     0, 0, "rst_err");
        expect_val(K_INST,    0, 0, "rst_inst0");
        drain();

        // Single word MOV R0,#20
        pulse_start(1'b0, 8'h00);
        expect_val(K_READY, 0, 1, "load_ld_ready");
        send_word(32'hE3A0_0014, 1'b1);
        expect_val(K_DONE, 0, 1, "w1_done");
        expect_val(K_WC,   0, 1, "w1_wc");
        expect_val(K_ERR,  0, 0, "w1_err");
        expect_val(K_READY,0, 0, "w1_ready_low");
        expect_val(K_INST, 0, 32'hE3A0_0014, "w1_inst0");
        expect_val(K_INST, 4, 0, "w1_inst4");
        drain();

        // Three words with 0-3 idle cycles between bytes
        w3[0] = 32'hE3A0_0014; w3[1] = 32'hE3A0_1A01; w3[2] = 32'hE3A0_2103;
        for (int i = 0; i < 12; i++) bytes3[i] = w3[i/4][31-8*(i%4) -: 8];
        pulse_start(1'b0, 8'h00);
        for (int i = 0; i < 12; i++) send(bytes3[i], i == 11, i % 4, 1'b1);
        expect_val(K_INST, 0,  32'hE3A0_0014, "w3_inst0");
        expect_val(K_INST, 4,  32'hE3A0_1A01, "w3_inst4");
        expect_val(K_INST, 8,  32'hE3A0_2103, "w3_inst8");
        expect_val(K_INST, 2,  32'hE3A0_0014, "w3_inst2_unaligned");
        expect_val(K_INST, 12, 0, "w3_inst12");
        expect_val(K_INST, 32'h0000_1000, 0, "w3_inst_high_addr");
        expect_val(K_WC,   0, 3, "w3_wc");
        expect_val(K_ERR,  0, 0, "w3_err");
        drain();

        // Partial last word: E2 80 -> zero padded, err
        pulse_start(1'b0, 8'h00);
        send(8'hE2, 1'b0, 0, 1'b0);
        send(8'h80, 1'b1, 0, 1'b0);
        expect_val(K_INST, 0, 32'hE280_0000, "part_inst0");
        expect_val(K_ERR,  0, 1, "part_err");
        expect_val(K_WC,   0, 1, "part_wc");
        expect_val(K_DONE, 0, 1, "part_done");
        drain();

        // Overflow of the 4-word instance: 16 bytes with no ld_last
        pulse_start(1'b0, 8'h00);
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 0, 1'b0);
        expect_val(K_DONE4,  0, 1, "ovf_done");
        expect_val(K_ERR4,   0, 1, "ovf_err");
        expect_val(K_READY4, 0, 0, "ovf_ready");
        expect_val(K_WC4,    0, 4, "ovf_wc");
        drain();
        send(8'hFF, 1'b0, 0, 1'b0);   // 17th byte must be ignored
        expect_val(K_WC4,    0,  4, "ovf17_wc");
        expect_val(K_ERR4,   0,  1, "ovf17_err");
        expect_val(K_DONE4,  0,  1, "ovf17_done");
        expect_val(K_INST4,  0,  32'h0001_0203, "ovf_inst0");
        expect_val(K_INST4,  12, 32'h0C0D_0E0F, "ovf_inst12");
        drain();

        // Reset in the middle of a load, then reload
        pulse_start(1'b0, 8'h00);
        for (int i = 0; i < 6; i++) send(8'h10 + 8'(i), 1'b0, 0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        expect_val(K_READY,   0, 0, "mrst_ready");
        expect_val(K_LOADING, 0, 0, "mrst_loading");
        expect_val(K_DONE,    0, 0, "mrst_done");
        expect_val(K_WC,      0, 0, "mrst_wc");
        expect_val(K_ERR,     0, 0, "mrst_err");
        expect_val(K_INST,    0, 0, "mrst_inst0");
        expect_val(K_DONE4,   0, 0, "mrst_done4");
        drain();
        pulse_start(1'b0, 8'h00);
        send_word(32'hAABB_CCDD, 1'b1);
        expect_val(K_WC,   0, 1, "reload_wc");
        expect_val(K_INST, 0, 32'hAABB_CCDD, "reload_inst0");
        drain();

        // Two words, then a one-word session hides the stale second word.
        pulse_start(1'b0, 8'h00);
        send_word(32'h1122_3344, 1'b0);
        send_word(32'h5566_7788, 1'b1);
        expect_val(K_INST, 4, 32'h5566_7788, "two_inst4");
        expect_val(K_WC,   0, 2, "two_wc");
        drain();
        pulse_start(1'b1, 8'hFF);     // byte on the start cycle is dropped
        send_word(32'h99AA_BBCC, 1'b1);
        expect_val(K_INST, 4, 0, "stale_inst4");
        expect_val(K_INST, 0, 32'h99AA_BBCC, "stale_inst0");
        expect_val(K_WC,   0, 1, "stale_wc");
        expect_val(K_ERR,  0, 0, "stale_err");
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
Writable instruction memory for the ARM pipeline. A byte-serial loader stream writes program words into an internal RAM. The IF stage reads instructions through the same combinational fetch port the hard-coded ROM provides today. Programs can be reloaded without resynthesis, and the core is held until loading completes.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit instruction words stored
IDX_W, 10, word-index width; must equal clog2(DEPTH_WORDS)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
ld_start  in  1  one-cycle pulse; begins a new load session
ld_valid  in  1  loader byte valid
ld_byte  in  8  loader byte; the first byte of each word is the MSB
ld_last  in  1  marks the final byte of the program; qualified by ld_valid
ld_ready  out  1  block can accept a byte this cycle
address  in  32  fetch byte address from the IF stage (PC)
Inst  out  32  fetched instruction, combinational
loading  out  1  high while in LOAD; the core must be held in reset/freeze
load_done  out  1  high in DONE; program valid
word_count  out  IDX_W+1  number of words written in the current session
err  out  1  sticky error for the session: partial last word, or overflow

Behaviour:
- Reset values: state=IDLE; ld_ready=0, loading=0, load_done=0, word_count=0, err=0. Byte counter and shift register are 0. RAM contents are not reset.
- FSM states and transitions:
  - IDLE -> LOAD on ld_start.
  - LOAD -> DONE on an accepted byte with ld_last=1, or when the word filling the last slot (DEPTH_WORDS-1) is written.
  - DONE -> LOAD on ld_start.
  - ld_start in LOAD restarts the session.
- On entering LOAD (any ld_start): word_count=0, byte counter=0, err=0.
- ld_ready = (state==LOAD). A byte is accepted iff ld_valid && ld_ready.
- Byte assembly: accepted bytes shift into a 32-bit register, MSB first (byte0 -> [31:24], byte3 -> [7:0]). This matches big-endian {mem[a],mem[a+1],mem[a+2],mem[a+3]} fetch order.
- On the 4th accepted byte of a word, at the same clock edge:
  - mem[word_count] <= assembled word
  - word_count increments
  - byte counter wraps to 0
- ld_last on byte k<4 of a word:
  - the remaining low bytes are zero-padded;
  - the word is written on that edge and word_count increments;
  - err=1;
  - go to DONE.
- Last-slot write without ld_last: go to DONE and set err=1. A last-slot write with ld_last: DONE with err unchanged.
- ld_valid while ld_ready=0 is ignored, with no state change and no error.
- Fetch port (combinational):
  - idx = address[IDX_W+1:2]; address[1:0] is ignored (word-aligned fetch).
  - Inst = mem[idx] only when state==DONE, address[31:IDX_W+2]==0, and idx<word_count.
  - Otherwise Inst = 32'b0 (NOP encoding used by the pipeline).
- Reset mid-load: everything returns to IDLE and Inst=0. A partial word is discarded, and RAM keeps any stale data, which stays invisible because word_count=0.
- ld_start and an accepted byte in the same cycle: ld_start wins and the byte is dropped. The loader must not drive ld_valid on the start cycle.
- Write and read of the same index in one cycle cannot occur, since reads are gated by state==DONE.

Test Plan:
- Reset, ld_start, then bytes E3 A0 00 14 with ld_last on the 4th -> load_done=1, word_count=1, err=0; address=0 gives Inst=32'hE3A00014 (MOV R0,#20); address=4 gives Inst=0.
- Load 3 words E3A00014, E3A01A01, E3A02103 with ld_valid gaps of 0-3 idle cycles -> address 0/4/8 return those words; address 2 returns E3A00014; address 12 returns 0; loading=1 throughout the load.
- Bytes E2 80 with ld_last on the 2nd -> Inst@0=32'hE2800000, err=1, word_count=1.
- DEPTH_WORDS=4, 16 bytes without ld_last -> DONE after the 16th byte, err=1, ld_ready=0; a 17th ld_valid byte is ignored.
- rst asserted after 6 bytes -> all outputs return to reset values; ld_start plus a 4-byte reload gives word_count=1 and the correct Inst@0.
- From DONE with 2 words loaded, ld_start followed by 1 word -> Inst@4 reads 0 (stale word hidden) and word_count=1.
